rv32m_muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the RV32M multiply/divide operations: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Sits beside the RV32I ALU in the backend. The decoder raises start for an M-extension mnemonic, and the block stalls the single-cycle core until the result is ready.
- Replaces the combinational a*b path with an iterative shift-add multiplier and a restoring divider, both sequenced by an FSM.

---
 rtl/be_pkg.sv | 34 +++
 rtl/muldiv_step.sv | 37 +++
 rtl/rv32m_muldiv_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_rv32m_muldiv_sequencer.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/be_pkg.sv
// Backend shared types for the RV32M multiply/divide sequencer: op and state
// enums, fixed special-case answers and the operand signedness helper.
package be_pkg;

    typedef logic [31:0] RV32I_OPERAND_t;

    // Encoded exactly as the instruction's funct3 field.
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } MULDIV_OP_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PREP = 2'd1,
        ST_RUN  = 2'd2,
        ST_FIN  = 2'd3
    } MULDIV_STATE_t;

    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    // True when rs1 is interpreted as signed; rs2 is signed for the same ops except MULHSU.
    function automatic logic is_signed_op(input MULDIV_OP_t op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational radix-2 step: shift-add multiply or restoring divide,
// selected by div_mode_i. hi/lo hold product halves or remainder/quotient.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            div_mode_i,
    input  logic [XLEN:0]   hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] m_i,
    output logic [XLEN:0]   hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        sum     = hi_i + {1'b0, (m_i & {XLEN{lo_i[0]}})};
        shifted = {hi_i[XLEN-1:0], lo_i[XLEN-1]};
        // Remainder < divisor, so a 33-bit difference always carries the true sign in its MSB.
        trial   = shifted - {1'b0, m_i};
        if (div_mode_i) begin
            if (trial[XLEN]) begin
                hi_o = shifted;
                lo_o = {lo_i[XLEN-2:0], 1'b0};
            end else begin
                hi_o = trial;
                lo_o = {lo_i[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_o = {1'b0, sum[XLEN:1]};
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/rv32m_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer (IDLE/PREP/RUN/FIN) stalling the core.
// Optional RV32M_FAST_MUL_EN: MUL-class ops use a single-cycle product in PREP.
module rv32m_muldiv_sequencer
    import be_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN / UNROLL + 1);

    MULDIV_STATE_t   state_q, state_d;
    MULDIV_OP_t      op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;
    logic [XLEN-1:0] m_q, m_d;
    logic [XLEN:0]   hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic            neg_q, neg_d;
    logic            neg_rem_q, neg_rem_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            is_div;
    logic            s1, s2;
    logic [XLEN-1:0] mag1, mag2;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0] quo_fix, rem_fix, fin_val;

    logic [XLEN:0]   hi_c [UNROLL+1];
    logic [XLEN-1:0] lo_c [UNROLL+1];

    assign is_div  = op_q[2];
    assign hi_c[0] = hi_q;
    assign lo_c[0] = lo_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        muldiv_step #(.XLEN(XLEN)) u_step (
            .div_mode_i (is_div),
            .hi_i       (hi_c[g]),
            .lo_i       (lo_c[g]),
            .m_i        (m_q),
            .hi_o       (hi_c[g+1]),
            .lo_o       (lo_c[g+1])
        );
    end

`ifdef RV32M_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
    // Sign/zero-extended operands give the same low 64 bits as a 33x33 signed product.
    assign fast_a = {{XLEN{s1}}, rs1_q};
    assign fast_b = {{XLEN{s2}}, rs2_q};
    assign fast_p = fast_a * fast_b;
`endif

    always_comb begin
        s1   = rs1_q[XLEN-1] & is_signed_op(op_q);
        s2   = rs2_q[XLEN-1] & is_signed_op(op_q) & (op_q != OP_MULHSU);
        mag1 = s1 ? (~rs1_q + 1'b1) : rs1_q;
        mag2 = s2 ? (~rs2_q + 1'b1) : rs2_q;

        prod     = {hi_q[XLEN-1:0], lo_q};
        prod_fix = neg_q ? (~prod + 1'b1) : prod;
        quo_fix  = neg_q ? (~lo_q + 1'b1) : lo_q;
        rem_fix  = neg_rem_q ? (~hi_q[XLEN-1:0] + 1'b1) : hi_q[XLEN-1:0];
        case (op_q)
            OP_MUL:                         fin_val = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   fin_val = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                fin_val = quo_fix;
            default:                        fin_val = rem_fix;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        m_d       = m_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        count_d   = count_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PREP;
                    op_d    = MULDIV_OP_t'(op);
                    rs1_d   = rs1;
                    rs2_d   = rs2;
                end
            end
            ST_PREP: begin
                count_d = CNT_W'(XLEN / UNROLL);
                state_d = ST_RUN;
                if (is_div) begin
                    hi_d      = '0;
                    lo_d      = mag1;
                    m_d       = mag2;
                    neg_d     = s1 ^ s2;
                    neg_rem_d = s1;
                    // Fixed answers are staged in hi/lo so FIN's normal select picks them up.
                    if (rs2_q == '0) begin
                        hi_d      = {1'b0, rs1_q};
                        lo_d      = DIV_BY_ZERO_Q;
                        neg_d     = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = ST_FIN;
                    end else if (((op_q == OP_DIV) || (op_q == OP_REM)) &&
                                 (rs1_q == INT_MIN) && (rs2_q == '1)) begin
                        hi_d      = '0;
                        lo_d      = INT_MIN;
                        neg_d     = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = ST_FIN;
                    end
                end else begin
                    hi_d      = '0;
                    lo_d      = mag2;
                    m_d       = mag1;
                    neg_d     = s1 ^ s2;
                    neg_rem_d = 1'b0;
`ifdef RV32M_FAST_MUL_EN
                    hi_d      = {1'b0, fast_p[2*XLEN-1:XLEN]};
                    lo_d      = fast_p[XLEN-1:0];
                    neg_d     = 1'b0;
                    state_d   = ST_FIN;
`endif
                end
            end
            ST_RUN: begin
                hi_d    = hi_c[UNROLL];
                lo_d    = lo_c[UNROLL];
                count_d = count_q - 1'b1;
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                result_d = fin_val;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_MUL;
            rs1_q     <= '0;
            rs2_q     <= '0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            m_q       <= m_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // Result is visible with the done pulse and held from the register afterwards.
    assign result = (state_q == ST_FIN) ? fin_val : result_q;
    assign done   = (state_q == ST_FIN);
    assign busy   = (state_q != ST_IDLE);
    assign stall  = ((state_q == ST_IDLE) & start) | (state_q == ST_PREP) | (state_q == ST_RUN);

endmodule

// File: tb/tb_rv32m_muldiv_sequencer.sv
// Directed bench for rv32m_muldiv_sequencer: results, latency, stall timeline,
// ignored starts and mid-operation reset.
module tb_rv32m_muldiv_sequencer;

    localparam int TB_UNROLL = 1;
    localparam int DIV_LAT   = 2 + 32 / TB_UNROLL;
`ifdef RV32M_FAST_MUL_EN
    localparam int MUL_LAT   = 2;
`else
    localparam int MUL_LAT   = 2 + 32 / TB_UNROLL;
`endif
    localparam int LIMIT     = 200;

    localparam logic [2:0] MUL = 3'd0, MULH = 3'd1, MULHSU = 3'd2, MULHU = 3'd3;
    localparam logic [2:0] DIV = 3'd4, DIVU = 3'd5, REM = 3'd6, REMU = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        stall, busy, done;
    logic [31:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rv32m_muldiv_sequencer #(.XLEN(32), .UNROLL(TB_UNROLL)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts one op in cycle 0 and follows it to done; optionally pulses start in cycle pulse_cyc.
    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                         input int pulse_cyc);
        int lat = -1;
        int stall_errs = 0;
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        @(negedge clk);
        check_eq({tag, "_busy_c0"}, 64'(busy), 64'd0);
        if (!stall) stall_errs++;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; rs1 = '0; rs2 = '0;
        for (int c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                if (stall) stall_errs++;
                break;
            end
            if (!stall) stall_errs++;
            @(posedge clk); #1;
            start = (c + 1 == pulse_cyc);
            if (start) begin
                op = MUL; rs1 = 32'h0000_1234; rs2 = 32'h0000_0055;
            end
        end
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check_eq({tag, "_result"}, 64'(result), 64'(exp));
        check_eq({tag, "_stall"}, 64'(stall_errs), 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
        check_eq({tag, "_done_after"}, 64'(done), 64'd0);
        check_eq({tag, "_held"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int extra_done;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_stall", 64'(stall), 64'd0);
        check_eq("rst_result", 64'(result), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_op("mul_neg",    MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, -1);
        do_op("mulh_min",   MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MUL_LAT, -1);
        do_op("mulhu_max",  MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, -1);
        do_op("mulhsu_max", MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, -1);
        do_op("div_neg",    DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, DIV_LAT, -1);
        do_op("rem_neg",    REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, DIV_LAT, -1);
        do_op("divu_100_7", DIVU,   32'd100,        32'd7,         32'd14,        DIV_LAT, -1);
        do_op("remu_100_7", REMU,   32'd100,        32'd7,         32'd2,         DIV_LAT, -1);
        do_op("divu_by0",   DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 2,       -1);
        do_op("remu_by0",   REMU,   32'd5,          32'd0,         32'd5,         2,       -1);
        do_op("div_ovf",    DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2,       -1);
        do_op("rem_ovf",    REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2,       -1);
        do_op("div_ign",    DIVU,   32'd1000,       32'd10,        32'd100,       DIV_LAT, 5);

        // Reset in RUN cycle 10 must abandon the op without a done or a result.
        @(posedge clk); #1;
        start = 1'b1; op = MUL; rs1 = 32'd9; rs2 = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rstrun_busy", 64'(busy), 64'd0);
        check_eq("rstrun_done", 64'(done), 64'd0);
        check_eq("rstrun_result", 64'(result), 64'd0);
        check_eq("rstrun_stall", 64'(stall), 64'd0);
        extra_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) extra_done++;
        end
        check_eq("rstrun_no_done", 64'(extra_done), 64'd0);

        do_op("mul_3x4", MUL, 32'd3, 32'd4, 32'd12, MUL_LAT, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
